// File: rtl/tetris_input_ctrl.sv
// Push-button front end for the game logic: synchronise, debounce, emit one-cycle command pulses.
// Define TETRIS_INPUT_AUTOREPEAT_EN to add DAS/ARR auto-repeat on down/left/right.
module tetris_input_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] DAS_DELAY       = 24'd10000000,
    parameter logic [23:0] ARR_PERIOD      = 24'd2500000
) (
    input  logic       gm_clk,
    input  logic       gm_rst_n,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rot,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       rott,
    output logic [3:0] held
);
    // Channel order everywhere: {rot, right, left, down}.
    logic [3:0]       raw_s;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       level_q;
    logic [3:0]       level_d;
    logic [3:0]       prev_q;
    logic [3:0][15:0] stab_q;
    logic [3:0][15:0] stab_d;
    logic [3:0]       pulse_q;
    logic [3:0]       pulse_d;
    logic [3:0]       rise_s;
    logic             lr_both_s;
    logic [2:0]       block_s;
    logic [2:0]       fire_s;

    assign raw_s     = {btn_rot, btn_right, btn_left, btn_down};
    assign rise_s    = level_q & ~prev_q;
    // Conflict looks at the upcoming level so no left/right pulse leaks out on the edge it begins.
    assign lr_both_s = level_d[1] & level_d[2];
    assign block_s   = {lr_both_s, lr_both_s, 1'b0};
    assign pulse_d   = {rise_s[3], fire_s};

    // Per-channel debounce: level flips after DEBOUNCE_CYCLES differing samples, counter saturates.
    always_comb begin
        level_d = level_q;
        stab_d  = stab_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                stab_d[i] = 16'd0;
            end else if (stab_q[i] >= DEBOUNCE_CYCLES) begin
                level_d[i] = sync2_q[i];
                stab_d[i]  = 16'd0;
            end else if (stab_q[i] != 16'hFFFF) begin
                stab_d[i] = stab_q[i] + 16'd1;
            end else begin
                stab_d[i] = stab_q[i];
            end
        end
    end

    // Synchronisers, debounce state and the registered pulse outputs.
    always_ff @(posedge gm_clk or negedge gm_rst_n) begin
        if (!gm_rst_n) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            level_q <= 4'b0000;
            prev_q  <= 4'b0000;
            stab_q  <= {4{16'd0}};
            pulse_q <= 4'b0000;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            stab_q  <= stab_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef TETRIS_INPUT_AUTOREPEAT_EN
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [2:0][1:0]  state_q;
    logic [2:0][1:0]  state_d;
    logic [2:0][23:0] cnt_q;
    logic [2:0][23:0] cnt_d;

    // DAS/ARR sequencer for down, left and right; the counter fires on its last non-zero count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_s  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            case (state_q[i])
                ST_IDLE: begin
                    if (rise_s[i] && !block_s[i]) begin
                        fire_s[i]  = 1'b1;
                        state_d[i] = ST_DELAY;
                        cnt_d[i]   = DAS_DELAY;
                    end else begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = 24'd0;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (!level_q[i] || block_s[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = 24'd0;
                    end else if (cnt_q[i] <= 24'd1) begin
                        fire_s[i]  = 1'b1;
                        state_d[i] = ST_REPEAT;
                        cnt_d[i]   = ARR_PERIOD;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 24'd1;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = 24'd0;
                end
            endcase
        end
    end

    // Auto-repeat state registers.
    always_ff @(posedge gm_clk or negedge gm_rst_n) begin
        if (!gm_rst_n) begin
            state_q <= {3{ST_IDLE}};
            cnt_q   <= {3{24'd0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic unused_cfg_s;

    assign unused_cfg_s = ^{DAS_DELAY, ARR_PERIOD};
    assign fire_s       = rise_s[2:0] & ~block_s;
`endif

    assign {rott, right, left, down} = pulse_q;
    assign held                      = level_q;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl with DEBOUNCE_CYCLES=4, DAS_DELAY=10, ARR_PERIOD=3.
// Expectations follow TETRIS_INPUT_AUTOREPEAT_EN as seen by this compile.
module tb_tetris_input_ctrl;
`ifdef TETRIS_INPUT_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       gm_clk;
    logic       gm_rst_n;
    logic [3:0] btn_v;
    logic       down;
    logic       left;
    logic       right;
    logic       rott;
    logic [3:0] held;
    logic [3:0] pulse_w;
    int         checks;
    int         failures;

    assign pulse_w = {rott, right, left, down};

    tetris_input_ctrl #(
        .DEBOUNCE_CYCLES(16'd4),
        .DAS_DELAY      (24'd10),
        .ARR_PERIOD     (24'd3)
    ) dut (
        .gm_clk   (gm_clk),
        .gm_rst_n (gm_rst_n),
        .btn_down (btn_v[0]),
        .btn_left (btn_v[1]),
        .btn_right(btn_v[2]),
        .btn_rot  (btn_v[3]),
        .down     (down),
        .left     (left),
        .right    (right),
        .rott     (rott),
        .held     (held)
    );

    initial gm_clk = 1'b0;
    always #5 gm_clk = ~gm_clk;

    task automatic step();
        @(posedge gm_clk);
        #1;
    endtask

    task automatic idle_all();
        btn_v = 4'b0000;
        repeat (16) step();
    endtask

    task automatic test_reset();
        gm_rst_n = 1'b1;
        btn_v    = 4'b1111;
        #1;
        gm_rst_n = 1'b0;
        #2;
        checks++;
        if (pulse_w !== 4'b0000 || held !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async pulses=%b held=%b expected 0000/0000", pulse_w, held);
        end
        step();
        step();
        checks++;
        if (pulse_w !== 4'b0000 || held !== 4'b0000) begin
            failures++;
            $display("FAIL reset_clocked pulses=%b held=%b expected 0000/0000", pulse_w, held);
        end
    endtask

    // down and rot held through reset release: both pulse together 7 edges later.
    task automatic test_held_at_reset();
        logic [3:0] exp_p;
        logic [3:0] exp_h;
        btn_v = 4'b1001;
        step();
        gm_rst_n = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            step();
            exp_p = (e == 7) ? 4'b1001 : 4'b0000;
            exp_h = (e >= 6) ? 4'b1001 : 4'b0000;
            checks++;
            if (pulse_w !== exp_p) begin
                failures++;
                $display("FAIL held_at_reset_pulse edge=%0d got=%b exp=%b", e, pulse_w, exp_p);
            end
            checks++;
            if (held !== exp_h) begin
                failures++;
                $display("FAIL held_at_reset_level edge=%0d got=%b exp=%b", e, held, exp_h);
            end
        end
        idle_all();
    endtask

    // One button held 40 cycles: pulse at 7, then (auto-repeat) 17, 20, ..., 38.
    task automatic test_hold(input int ch);
        logic [3:0] exp_p;
        logic [3:0] exp_h;
        btn_v     = 4'b0000;
        btn_v[ch] = 1'b1;
        for (int e = 0; e <= 40; e++) begin
            if (e == 40) btn_v = 4'b0000;
            step();
            exp_p = 4'b0000;
            exp_h = 4'b0000;
            if (e == 7 || (AR && ch != 3 && e >= 17 && ((e - 17) % 3) == 0)) exp_p[ch] = 1'b1;
            if (e >= 6) exp_h[ch] = 1'b1;
            checks++;
            if (pulse_w !== exp_p) begin
                failures++;
                $display("FAIL hold_pulse ch=%0d edge=%0d got=%b exp=%b", ch, e, pulse_w, exp_p);
            end
            checks++;
            if (held !== exp_h) begin
                failures++;
                $display("FAIL hold_level ch=%0d edge=%0d got=%b exp=%b", ch, e, held, exp_h);
            end
        end
        idle_all();
    endtask

    // rot bounces 1,0,1,0 then holds: debounced at edge 10, single pulse at edge 11.
    task automatic test_bounce();
        logic [3:0] exp_p;
        logic [3:0] exp_h;
        int         npulse;
        npulse = 0;
        for (int e = 0; e <= 33; e++) begin
            btn_v = 4'b0000;
            btn_v[3] = (e >= 4) ? 1'b1 : ((e % 2) == 0);
            step();
            npulse += int'(rott);
            exp_p = (e == 11) ? 4'b1000 : 4'b0000;
            exp_h = (e >= 10) ? 4'b1000 : 4'b0000;
            checks++;
            if (pulse_w !== exp_p) begin
                failures++;
                $display("FAIL bounce_pulse edge=%0d got=%b exp=%b", e, pulse_w, exp_p);
            end
            checks++;
            if (held !== exp_h) begin
                failures++;
                $display("FAIL bounce_level edge=%0d got=%b exp=%b", e, held, exp_h);
            end
        end
        checks++;
        if (npulse != 1) begin
            failures++;
            $display("FAIL bounce_count got=%0d exp=1", npulse);
        end
        idle_all();
    endtask

    // left held, right added at 12 (debounced 18, released 25 -> level falls at 31).
    task automatic test_conflict();
        logic [3:0] exp_p;
        logic [3:0] exp_h;
        for (int e = 0; e <= 44; e++) begin
            btn_v = {1'b0, (e >= 12 && e < 25), 1'b1, 1'b0};
            step();
            exp_p = (e == 7 || (AR && e == 17)) ? 4'b0010 : 4'b0000;
            exp_h = {1'b0, (e >= 18 && e <= 30), (e >= 6), 1'b0};
            checks++;
            if (pulse_w !== exp_p) begin
                failures++;
                $display("FAIL conflict_pulse edge=%0d got=%b exp=%b", e, pulse_w, exp_p);
            end
            checks++;
            if (held !== exp_h) begin
                failures++;
                $display("FAIL conflict_level edge=%0d got=%b exp=%b", e, held, exp_h);
            end
        end
        idle_all();
        btn_v = 4'b0010;
        for (int e = 0; e <= 9; e++) begin
            step();
            exp_p = (e == 7) ? 4'b0010 : 4'b0000;
            checks++;
            if (pulse_w !== exp_p) begin
                failures++;
                $display("FAIL conflict_repress edge=%0d got=%b exp=%b", e, pulse_w, exp_p);
            end
        end
        idle_all();
    endtask

    // down held; reset low after edge 15 for edges 16,17; restart counts from edge 18.
    task automatic test_reset_mid();
        logic [3:0] exp_p;
        logic [3:0] exp_h;
        for (int e = 0; e <= 33; e++) begin
            btn_v = (e < 30) ? 4'b0001 : 4'b0000;
            step();
            exp_p = (e == 7 || e == 25) ? 4'b0001 : 4'b0000;
            exp_h = ((e >= 6 && e <= 15) || e >= 24) ? 4'b0001 : 4'b0000;
            checks++;
            if (pulse_w !== exp_p) begin
                failures++;
                $display("FAIL rst_mid_pulse edge=%0d got=%b exp=%b", e, pulse_w, exp_p);
            end
            checks++;
            if (held !== exp_h) begin
                failures++;
                $display("FAIL rst_mid_level edge=%0d got=%b exp=%b", e, held, exp_h);
            end
            if (e == 15) begin
                gm_rst_n = 1'b0;
                #1;
                checks++;
                if (pulse_w !== 4'b0000 || held !== 4'b0000) begin
                    failures++;
                    $display("FAIL rst_mid_async pulses=%b held=%b expected 0000/0000", pulse_w, held);
                end
            end
            if (e == 17) gm_rst_n = 1'b1;
        end
        idle_all();
    endtask

    // Slow random toggling: no output high in adjacent cycles, never left and right together.
    task automatic test_random();
        logic [3:0] prev_p;
        int         npulse;
        int         b;
        prev_p = 4'b0000;
        npulse = 0;
        for (int c = 0; c < 20000; c++) begin
            if ($urandom_range(5, 0) == 0) begin
                b = int'($urandom_range(3, 0));
                btn_v[b] = ~btn_v[b];
            end
            step();
            npulse += $countones(pulse_w);
            checks++;
            if ((pulse_w & prev_p) !== 4'b0000) begin
                failures++;
                $display("FAIL random_adjacent cycle=%0d now=%b before=%b exp_overlap=0000", c, pulse_w, prev_p);
            end
            checks++;
            if ((pulse_w[1] & pulse_w[2]) !== 1'b0) begin
                failures++;
                $display("FAIL random_left_right cycle=%0d pulses=%b exp_both=0", c, pulse_w);
            end
            prev_p = pulse_w;
        end
        checks++;
        if (npulse == 0) begin
            failures++;
            $display("FAIL random_activity got=0 pulses exp>0");
        end
        idle_all();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        gm_rst_n = 1'b1;
        btn_v    = 4'b0000;
        test_reset();
        test_held_at_reset();
        for (int ch = 0; ch < 4; ch++) test_hold(ch);
        test_bounce();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
